// File: rtl/eco32f_cache_refill_if.sv
// Request/status, cache write port and Wishbone B3 master signals of the refill engine.
// master = the engine, slave = the cache/bus environment around it.
interface eco32f_cache_refill_if;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        inv_req;
  logic [31:0] inv_addr;
  logic        inv_all_req;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        write_en;
  logic        invalidate;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    input  refill_req, refill_addr, inv_req, inv_addr, inv_all_req,
    output busy, done, err,
    output write_addr, write_data, write_en, invalidate,
    output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output refill_req, refill_addr, inv_req, inv_addr, inv_all_req,
    input  busy, done, err,
    input  write_addr, write_data, write_en, invalidate,
    input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/eco32f_cache_refill.sv
// Cache line-fill / invalidation engine: bursts one line over Wishbone into the cache write
// port, invalidates one line, or sweeps every line. All outputs come straight from flops.
module eco32f_cache_refill #(
  parameter int NUM_LINES  = 128,
  parameter int LINE_WORDS = 8
) (
  input logic                   clk,
  input logic                   rst,
  eco32f_cache_refill_if.master bus
);

  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_LINES - 1);

  typedef enum logic [1:0] {IDLE, REFILL, INV_ALL, ERR_INV} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [26:0]   base_q, base_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          write_en_q, write_en_d;
  logic          invalidate_q, invalidate_d;
  logic [31:0]   write_addr_q, write_addr_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          cyc_q, cyc_d;
  logic [31:0]   adr_q, adr_d;
  logic [2:0]    cti_q, cti_d;

  // Offset bits of the request addresses are don't-care by definition.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.refill_addr[4:0], bus.inv_addr[4:0]};

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    idx_d        = idx_q;
    base_d       = base_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    write_en_d   = 1'b0;
    invalidate_d = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    cyc_d        = cyc_q;
    adr_d        = adr_q;
    cti_d        = cti_q;

    case (state_q)
      IDLE: begin
        if (bus.inv_all_req) begin
          state_d      = INV_ALL;
          idx_d        = '0;
          write_en_d   = 1'b1;
          invalidate_d = 1'b1;
          write_addr_d = '0;
          write_data_d = '0;
          done_d       = (LAST_IDX == '0);
        end else if (bus.inv_req) begin
          write_en_d   = 1'b1;
          invalidate_d = 1'b1;
          write_addr_d = {bus.inv_addr[31:5], 5'b0};
          write_data_d = '0;
          done_d       = 1'b1;
        end else if (bus.refill_req) begin
          state_d = REFILL;
          base_d  = bus.refill_addr[31:5];
          beat_d  = '0;
          cyc_d   = 1'b1;
          adr_d   = {bus.refill_addr[31:5], 5'b0};
          cti_d   = (LAST_BEAT == '0) ? 3'b111 : 3'b010;
        end
      end

      REFILL: begin
        // err wins over ack; the faulty beat is never written, the line is killed instead.
        if (bus.wbm_err_i) begin
          state_d      = ERR_INV;
          cyc_d        = 1'b0;
          cti_d        = 3'b000;
          write_en_d   = 1'b1;
          invalidate_d = 1'b1;
          write_addr_d = {base_q, 5'b0};
          write_data_d = '0;
          done_d       = 1'b1;
          err_d        = 1'b1;
        end else if (bus.wbm_ack_i) begin
          write_en_d   = 1'b1;
          write_addr_d = adr_q;
          write_data_d = bus.wbm_dat_i;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
            adr_d  = {base_q, 5'b0} + 32'({beat_d, 2'b00});
            cti_d  = (beat_d == LAST_BEAT) ? 3'b111 : 3'b010;
          end
        end
      end

      INV_ALL: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d        = idx_q + 1'b1;
          write_en_d   = 1'b1;
          invalidate_d = 1'b1;
          write_addr_d = 32'({idx_d, 5'b0});
          write_data_d = '0;
          done_d       = (idx_d == LAST_IDX);
        end
      end

      ERR_INV: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      idx_q        <= '0;
      base_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      write_en_q   <= 1'b0;
      invalidate_q <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      cyc_q        <= 1'b0;
      adr_q        <= '0;
      cti_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      write_en_q   <= write_en_d;
      invalidate_q <= invalidate_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      cyc_q        <= cyc_d;
      adr_q        <= adr_d;
      cti_q        <= cti_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.write_en   = write_en_q;
  assign bus.invalidate = invalidate_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.wbm_cyc_o  = cyc_q;
  assign bus.wbm_stb_o  = cyc_q;
  assign bus.wbm_adr_o  = adr_q;
  assign bus.wbm_cti_o  = cti_q;
  assign bus.wbm_bte_o  = 2'b00;

endmodule

// File: tb/tb_eco32f_cache_refill.sv
// Randomized bench for eco32f_cache_refill: Wishbone slave model with wait states / error
// injection, per-cycle output capture, and a line-level reference model of expected writes.
module tb_eco32f_cache_refill;
  localparam int NL = 128;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eco32f_cache_refill_if bif ();
  eco32f_cache_refill #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (.clk(clk), .rst(rst), .bus(bif));

  int n_tests = 0;
  int n_fail  = 0;

  // slave configuration
  int          wait_states = 0;
  int          err_beat    = -1;
  logic [31:0] key         = 32'hA5A5A5A5;
  int          s_wcnt      = 0;
  int          s_beat      = 0;

  always @(negedge clk) begin
    bif.wbm_ack_i = 1'b0;
    bif.wbm_err_i = 1'b0;
    if (bif.wbm_stb_o === 1'b1) begin
      if (s_wcnt == wait_states) begin
        s_wcnt = 0;
        if (s_beat == err_beat) bif.wbm_err_i = 1'b1;
        else begin
          bif.wbm_ack_i = 1'b1;
          bif.wbm_dat_i = bif.wbm_adr_o ^ key;
        end
        s_beat++;
      end else s_wcnt++;
    end else begin
      s_wcnt = 0;
      s_beat = 0;
    end
  end

  // captured behaviour
  logic [31:0] wr_addr[$], wr_data[$];
  logic        wr_inv[$];
  logic [31:0] ack_adr[$];
  logic [2:0]  ack_cti[$];
  int done_at, last_done, done_cnt, err_at, busy_cnt, busy_last, stb_cnt, viol;

  // expected behaviour
  logic [31:0] ex_addr[$], ex_data[$];
  logic        ex_inv[$];

  task automatic clear_exp();
    ex_addr.delete(); ex_data.delete(); ex_inv.delete();
  endtask

  // Line-level model: what a refill of addr writes, and the cycle its done lands on.
  task automatic model_refill(input logic [31:0] addr, input int w, input int e,
                              output int done_off, output bit is_err);
    logic [31:0] base;
    int nb;
    base   = addr & 32'hFFFF_FFE0;
    is_err = (e >= 0 && e < LW);
    nb     = is_err ? e : LW;
    for (int b = 0; b < nb; b++) begin
      ex_addr.push_back(base + 4 * b);
      ex_data.push_back((base + 4 * b) ^ key);
      ex_inv.push_back(1'b0);
    end
    if (is_err) begin
      ex_addr.push_back(base);
      ex_data.push_back(32'h0);
      ex_inv.push_back(1'b1);
      done_off = (w + 1) * (e + 1) + 1;
    end else done_off = (w + 1) * LW + 1;
  endtask

  task automatic drop_reqs();
    bif.refill_req  = 1'b0;
    bif.inv_req     = 1'b0;
    bif.inv_all_req = 1'b0;
  endtask

  // Cycle k = k cycles after the cycle in which the caller raised its request.
  task automatic collect(input int max_cyc, input int n_done, input int tail,
                         input int poke_k, input logic [31:0] poke_addr);
    logic pstb, pterm;
    logic [31:0] padr;
    logic [2:0] pcti;
    wr_addr.delete(); wr_data.delete(); wr_inv.delete();
    ack_adr.delete(); ack_cti.delete();
    done_at = -1; last_done = -1; done_cnt = 0; err_at = -1;
    busy_cnt = 0; busy_last = -1; stb_cnt = 0; viol = 0;
    pstb = 1'b0; pterm = 1'b0; padr = '0; pcti = '0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk); #1;
      drop_reqs();
      if (k == poke_k) begin
        bif.refill_req  = 1'b1;
        bif.refill_addr = poke_addr;
      end
      if (bif.write_en) begin
        wr_addr.push_back(bif.write_addr);
        wr_data.push_back(bif.write_data);
        wr_inv.push_back(bif.invalidate);
      end
      if (bif.done) begin
        done_cnt++; last_done = k;
        if (done_at < 0) done_at = k;
      end
      if (bif.err) err_at = k;
      if (bif.busy) begin busy_cnt++; busy_last = k; end
      if (bif.wbm_cyc_o !== bif.wbm_stb_o || bif.wbm_bte_o !== 2'b00) viol++;
      if (pstb && !pterm && bif.wbm_stb_o && (bif.wbm_adr_o !== padr || bif.wbm_cti_o !== pcti)) viol++;
      if (bif.wbm_stb_o) stb_cnt++;
      if (bif.wbm_stb_o && bif.wbm_ack_i && !bif.wbm_err_i) begin
        ack_adr.push_back(bif.wbm_adr_o);
        ack_cti.push_back(bif.wbm_cti_o);
      end
      pstb = bif.wbm_stb_o; pterm = bif.wbm_ack_i | bif.wbm_err_i;
      padr = bif.wbm_adr_o; pcti = bif.wbm_cti_o;
      if (done_cnt >= n_done && k >= last_done + tail) break;
    end
    drop_reqs();
  endtask

  task automatic start_refill(input logic [31:0] a);
    @(negedge clk); #1;
    bif.refill_addr = a;
    bif.refill_req  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drop_reqs();
    bif.refill_addr = '0; bif.inv_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({bif.busy, bif.done, bif.err, bif.write_en, bif.invalidate, bif.wbm_cyc_o, bif.wbm_stb_o} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0", {bif.busy, bif.done, bif.err, bif.write_en, bif.invalidate, bif.wbm_cyc_o, bif.wbm_stb_o});
    end
    n_tests++;
    if ({bif.write_addr, bif.write_data, bif.wbm_adr_o} !== 96'h0) begin
      n_fail++; $display("FAIL reset_addr got %h %h %h exp 0", bif.write_addr, bif.write_data, bif.wbm_adr_o);
    end
    n_tests++;
    if ({bif.wbm_cti_o, bif.wbm_bte_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_cti got %b exp 0", {bif.wbm_cti_o, bif.wbm_bte_o});
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic check_writes(input string nm);
    n_tests++;
    if (wr_addr.size() != ex_addr.size()) begin
      n_fail++; $display("FAIL %s_count got %0d exp %0d", nm, wr_addr.size(), ex_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < ex_addr.size(); i++) begin
      n_tests++;
      if (wr_addr[i] !== ex_addr[i] || wr_inv[i] !== ex_inv[i] || (!ex_inv[i] && wr_data[i] !== ex_data[i])) begin
        n_fail++;
        $display("FAIL %s_write[%0d] got %h/%h/%b exp %h/%h/%b", nm, i, wr_addr[i], wr_data[i], wr_inv[i], ex_addr[i], ex_data[i], ex_inv[i]);
      end
    end
  endtask

  task automatic check_bus(input logic [31:0] a, input string nm);
    n_tests++;
    if (ack_adr.size() != LW) begin
      n_fail++; $display("FAIL %s_beats got %0d exp %0d", nm, ack_adr.size(), LW);
    end
    for (int b = 0; b < ack_adr.size() && b < LW; b++) begin
      n_tests++;
      if (ack_adr[b] !== (a & 32'hFFFF_FFE0) + 4 * b || ack_cti[b] !== ((b == LW - 1) ? 3'b111 : 3'b010)) begin
        n_fail++; $display("FAIL %s_beat[%0d] got %h/%b", nm, b, ack_adr[b], ack_cti[b]);
      end
    end
    n_tests++;
    if (viol != 0) begin n_fail++; $display("FAIL %s_bus_stable got %0d exp 0", nm, viol); end
  endtask

  task automatic test_refill(input logic [31:0] a, input int w, input string nm);
    int d; bit e;
    wait_states = w; err_beat = -1; key = 32'hA5A5A5A5;
    clear_exp(); model_refill(a, w, -1, d, e);
    start_refill(a);
    collect(200, 1, 3, -1, '0);
    check_writes(nm);
    check_bus(a, nm);
    n_tests++;
    if (done_at != d || done_cnt != 1 || err_at != -1) begin
      n_fail++; $display("FAIL %s_done got at %0d cnt %0d err %0d exp at %0d", nm, done_at, done_cnt, err_at, d);
    end
    n_tests++;
    if (busy_cnt != d - 1 || busy_last != d - 1) begin
      n_fail++; $display("FAIL %s_busy got %0d/%0d exp %0d", nm, busy_cnt, busy_last, d - 1);
    end
  endtask

  task automatic test_refill_err();
    int d; bit e;
    wait_states = 0; err_beat = 3; key = 32'hA5A5A5A5;
    clear_exp(); model_refill(32'h8000_0040, 0, 3, d, e);
    start_refill(32'h8000_0040);
    collect(200, 1, 3, -1, '0);
    check_writes("err");
    n_tests++;
    if (done_at != d || err_at != d || done_cnt != 1) begin
      n_fail++; $display("FAIL err_done got %0d/%0d exp %0d", done_at, err_at, d);
    end
    n_tests++;
    if (stb_cnt != 4 || busy_last != d) begin
      n_fail++; $display("FAIL err_stb_busy got stb %0d busy_last %0d exp 4 %0d", stb_cnt, busy_last, d);
    end
    err_beat = -1;
  endtask

  task automatic test_inv_all();
    @(negedge clk); #1;
    bif.inv_all_req = 1'b1;
    collect(400, 1, 4, 50, 32'h0000_3000);
    n_tests++;
    if (wr_addr.size() != NL) begin n_fail++; $display("FAIL inv_all_count got %0d exp %0d", wr_addr.size(), NL); end
    for (int i = 0; i < wr_addr.size() && i < NL; i++) begin
      n_tests++;
      if (wr_addr[i] !== 32'(i * 32) || wr_inv[i] !== 1'b1 || wr_data[i] !== 32'h0) begin
        n_fail++; $display("FAIL inv_all_write[%0d] got %h/%b exp %h", i, wr_addr[i], wr_inv[i], i * 32);
      end
    end
    n_tests++;
    if (done_at != NL || done_cnt != 1 || busy_cnt != NL || busy_last != NL) begin
      n_fail++; $display("FAIL inv_all_timing got done %0d busy %0d/%0d exp %0d", done_at, busy_cnt, busy_last, NL);
    end
    n_tests++;
    if (stb_cnt != 0) begin n_fail++; $display("FAIL inv_all_ignored_refill got stb %0d exp 0", stb_cnt); end
  endtask

  task automatic test_inv_priority();
    logic [31:0] ia;
    for (int r = 0; r < 3; r++) begin
      ia = $urandom;
      @(negedge clk); #1;
      bif.inv_addr = ia; bif.inv_req = 1'b1;
      bif.refill_addr = $urandom; bif.refill_req = 1'b1;
      collect(20, 1, 3, -1, '0);
      n_tests++;
      if (wr_addr.size() != 1 || wr_addr[0] !== (ia & 32'hFFFF_FFE0) || wr_inv[0] !== 1'b1 || wr_data[0] !== 32'h0) begin
        n_fail++; $display("FAIL inv_line_write got n=%0d exp 1 addr %h", wr_addr.size(), ia & 32'hFFFF_FFE0);
      end
      n_tests++;
      if (done_at != 1 || busy_cnt != 0 || stb_cnt != 0) begin
        n_fail++; $display("FAIL inv_line_timing got done %0d busy %0d stb %0d exp 1 0 0", done_at, busy_cnt, stb_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    wait_states = 0; err_beat = -1;
    start_refill(32'h0000_5a40);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      drop_reqs();
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({bif.wbm_cyc_o, bif.wbm_stb_o, bif.write_en, bif.busy, bif.done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_mid got %b exp 0", {bif.wbm_cyc_o, bif.wbm_stb_o, bif.write_en, bif.busy, bif.done});
    end
    rst = 1'b1;
    @(negedge clk);
    test_refill(32'h0000_77c8, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int d1, d2; bit e;
    wait_states = 0; err_beat = -1; key = $urandom;
    clear_exp();
    model_refill(32'h1111_2200, 0, -1, d1, e);
    model_refill(32'h2222_3340, 0, -1, d2, e);
    start_refill(32'h1111_2200);
    collect(100, 2, 3, d1, 32'h2222_3340);
    check_writes("b2b");
    n_tests++;
    if (done_cnt != 2 || done_at != d1 || last_done != d1 + d2) begin
      n_fail++; $display("FAIL b2b_done got %0d at %0d,%0d exp 2 at %0d,%0d", done_cnt, done_at, last_done, d1, d1 + d2);
    end
  endtask

  task automatic test_random();
    logic [31:0] a; int w, e, d; bit is_err;
    for (int r = 0; r < 20; r++) begin
      a = $urandom; w = $urandom_range(0, 3);
      e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, LW - 1) : -1;
      key = $urandom; wait_states = w; err_beat = e;
      clear_exp(); model_refill(a, w, e, d, is_err);
      start_refill(a);
      collect(200, 1, 2, -1, '0);
      check_writes("rand");
      n_tests++;
      if (done_at != d || (err_at == d) != is_err || viol != 0) begin
        n_fail++; $display("FAIL rand_done a=%h w=%0d e=%0d got %0d err %0d viol %0d exp %0d", a, w, e, done_at, err_at, viol, d);
      end
    end
    err_beat = -1;
  endtask

  initial begin
    bif.wbm_ack_i = 1'b0; bif.wbm_err_i = 1'b0; bif.wbm_dat_i = '0;
    test_reset();
    test_refill(32'h0000_1234, 0, "zero_wait");
    test_refill(32'h0000_1234, 2, "wait2");
    test_refill_err();
    test_inv_all();
    test_inv_priority();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/eco32f_cache_refill.md
# eco32f_cache_refill

Line-fill and invalidation engine that drives the write side of an eco32f cache (one way, 128 lines x 32 bytes, 4 kbyte). On a miss it bursts one 32-byte line from a Wishbone B3 master port and writes it word-by-word into the cache's write_addr/write_data/write_en/invalidate port. It also invalidates a single line or sweeps all lines. One instance sits beside each of the icache and the dcache.

## Interface
- NUM_LINES, 128, lines per way; power of two; line index is write_addr[11:5].
- LINE_WORDS, 8, 32-bit words per line; power of two; burst length.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- refill_req  in  1  single-cycle pulse: fill line containing refill_addr; ignored while busy.
- refill_addr  in  32  miss address; bits [4:0] ignored.
- inv_req  in  1  single-cycle pulse: invalidate line containing inv_addr; ignored while busy.
- inv_addr  in  32  bits [11:5] select the line.
- inv_all_req  in  1  single-cycle pulse: invalidate every line; ignored while busy.
- busy  out  1  engine in a multi-cycle operation (state != IDLE).
- done  out  1  one-cycle pulse on completion of any operation.
- err  out  1  one-cycle pulse with done when a refill ended by bus error.
- write_addr  out  32  cache write address (tag from [31:12], index [11:5], word [4:2]).
- write_data  out  32  cache write data.
- write_en  out  1  cache write strobe.
- invalidate  out  1  with write_en: store valid bit as 0.
- wbm_adr_o  out  32  bus address, word aligned.
- wbm_dat_i  in  32  bus read data.
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle/strobe; always equal.
- wbm_cti_o  out  3  010 incrementing burst, 111 final beat.
- wbm_bte_o  out  2  always 00 (linear).
- wbm_ack_i, wbm_err_i  in  1  slave termination; err has priority when both high.

## Operation
- States: IDLE, REFILL, INV_ALL, ERR_INV.
- Request priority in IDLE: inv_all_req > inv_req > refill_req; lower-priority same-cycle requests are dropped.
- Line base = {addr[31:5], 5'b0}. Beat counter width log2(LINE_WORDS), index counter width log2(NUM_LINES); both reset to 0 on each operation start.
- REFILL: wbm_adr_o = base + 4*beat; cti=010 for beats 0..LINE_WORDS-2, 111 for last. Each ack: next cycle write_en=1, invalidate=0, write_addr = acknowledged address, write_data = wbm_dat_i captured at ack; beat+1. Last ack: drop cyc/stb, go IDLE; done with final write.
- Words fill in order offset 0..LINE_WORDS-1; no critical-word-first. Caller stalls until done (tag goes valid on first word).
- Bus error in REFILL: drop cyc/stb next cycle, go ERR_INV; no data write for that beat. ERR_INV (1 cycle): write_en=1, invalidate=1, write_addr=base, done=1, err=1; go IDLE.
- inv_req (from IDLE, no state change): next cycle write_en=1, invalidate=1, write_addr={inv_addr[31:5],5'b0}, write_data=0, done=1; busy stays 0.
- INV_ALL: one write per cycle, write_addr={20'b0, idx, 5'b0}, invalidate=1, write_data=0, idx 0..NUM_LINES-1; done with last write; go IDLE.
- Reset (any state, incl. mid-burst): next cycle all outputs 0, state IDLE, counters 0. Cache contents untouched; the owner issues inv_all_req after reset.

## Timing
- All outputs registered. Reset values: busy, done, err, write_en, invalidate, wbm_cyc_o, wbm_stb_o = 0; write_addr, write_data, wbm_adr_o = 0; wbm_cti_o=000; wbm_bte_o=00.
- refill_req sampled at edge N: cyc/stb/adr=base, busy=1 from cycle N+1. Zero-wait slave: acks N+1..N+8, write_en N+2..N+9, busy low from N+9, done at N+9. Wait states stretch linearly; stb held with stable adr/cti until ack/err.
- New request accepted in the cycle busy is low, concurrent with the final refill write.
- inv_req at N: write_en and done at N+1.
- inv_all_req at N: write_en N+1..N+NUM_LINES, done at N+NUM_LINES, busy N+1..N+NUM_LINES.
- Error ack at cycle M: cyc/stb low at M+1, invalidate write + done + err at M+1, busy low at M+2.

## Test plan
- Refill 0x0000_1234, zero-wait slave returning adr^0xA5A5A5A5 -> wbm_adr_o 0x1220..0x123C, cti 010x7 then 111; write_en 8 cycles with matching data; done at N+9; err=0.
- Same refill, slave inserts 2 wait states per beat -> identical write sequence, done at N+25, stb/adr stable during waits.
- Refill 0x8000_0040, wbm_err_i on beat 3 -> 3 data writes, then one write_addr=0x8000_0040 invalidate=1 with done=err=1, cyc low next cycle.
- inv_all_req -> 128 writes, write_addr 0x000..0xFE0 step 0x20, invalidate=1; refill_req pulsed mid-sweep ignored.
- inv_req and refill_req same cycle -> only line invalidate, done at N+1, busy stays 0, no bus cycle.
- rst low at beat 4 of refill -> next cycle cyc/stb/write_en/busy all 0; after release refill_req works from beat 0.
